spi_shift_engine: RTL and testbench

SPI master shift engine directly downstream of the SPI register block: consumes the latched control bits (enable, CPOL, CPHA, continuous), clock divider and TX byte, and drives the SPI pins. It generates SCLK from the system clock, shifts one `D_WIDTH`-bit word out on MOSI while sampling MISO, and returns the received word with a `busy` flag and a one-cycle `rx_valid` strobe. One slave select line only.

---
 rtl/spi_shift_engine.sv | 251 +++++++++++++++++++++++++
 tb/tb_spi_shift_engine.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: SPI master shift engine with a single slave select.
// Generates SCLK from clk (half-period = clk_div+1 cycles), shifts one
// D_WIDTH-bit word out on mosi while sampling miso, and reports the received
// word with a one-cycle rx_valid strobe. Continuous mode chains words without
// releasing ss_n.
// Optional feature macro: SPI_SHIFT_LSB_FIRST_EN -- when defined, words are
// shifted out and assembled LSB first; otherwise MSB first in both directions.
module spi_shift_engine #(
    parameter int D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               cpol,
    input  logic               cpha,
    input  logic               cont,
    input  logic [7:0]         clk_div,
    input  logic [D_WIDTH-1:0] tx_data,
    input  logic               miso,
    output logic               sclk,
    output logic               mosi,
    output logic               ss_n,
    output logic               busy,
    output logic [D_WIDTH-1:0] rx_data,
    output logic               rx_valid
);
    localparam int EW = $clog2(2 * D_WIDTH + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * D_WIDTH);
    localparam logic [EW-1:0] EDGE_ONE  = EW'(1);
    localparam logic [EW-1:0] EDGE_ZERO = {EW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_TRAIL = 2'd2
    } state_t;

    // Bit that goes on the wire first for a given word.
    function automatic logic first_bit(input logic [D_WIDTH-1:0] w);
`ifdef SPI_SHIFT_LSB_FIRST_EN
        first_bit = w[0];
`else
        first_bit = w[D_WIDTH-1];
`endif
    endfunction

    // Discard the bit just driven so the next one moves into the first position.
    function automatic logic [D_WIDTH-1:0] shift_out(input logic [D_WIDTH-1:0] w);
`ifdef SPI_SHIFT_LSB_FIRST_EN
        shift_out = w >> 1;
`else
        shift_out = w << 1;
`endif
    endfunction

    // Append a received bit in wire order.
    function automatic logic [D_WIDTH-1:0] shift_in(input logic [D_WIDTH-1:0] w, input logic b);
`ifdef SPI_SHIFT_LSB_FIRST_EN
        shift_in = {b, w[D_WIDTH-1:1]};
`else
        shift_in = {w[D_WIDTH-2:0], b};
`endif
    endfunction

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [EW-1:0]        edge_q, edge_d;
    logic [7:0]           div_q, div_d;
    logic                 cpha_q, cpha_d;
    logic                 cont_q, cont_d;
    logic [D_WIDTH-1:0]   tx_sr_q, tx_sr_d;
    logic [D_WIDTH-1:0]   rx_sr_q, rx_sr_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;
    logic                 ss_n_q, ss_n_d;
    logic                 busy_q, busy_d;
    logic [D_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;

    logic                 wrap_s;
    logic                 edge_now_s;
    logic [EW-1:0]        edge_num_s;
    logic                 load_s;

    // Next-state and datapath logic for the idle, shifting and trailing phases.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        edge_d     = edge_q;
        div_d      = div_q;
        cpha_d     = cpha_q;
        cont_d     = cont_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        ss_n_d     = ss_n_q;
        busy_d     = busy_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        wrap_s     = (cnt_q == div_q);
        edge_now_s = 1'b0;
        edge_num_s = edge_q + EDGE_ONE;
        load_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // sclk tracks cpol through its own register while idle.
                sclk_d = cpol;
                ss_n_d = 1'b1;
                busy_d = 1'b0;
                cnt_d  = 8'd0;
                edge_d = EDGE_ZERO;
                if (enable) begin
                    state_d = ST_SHIFT;
                    ss_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    div_d   = clk_div;
                    cpha_d  = cpha;
                    cont_d  = cont;
                    load_s  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (wrap_s) begin
                    cnt_d = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (edge_q == LAST_EDGE) begin
                    rx_data_d  = rx_sr_q;
                    rx_valid_d = 1'b1;
                    if (cont_q && enable) begin
                        // Chain the next word; the half-period counter keeps running
                        // so its first edge lands one half-period after the last one.
                        cont_d     = cont;
                        load_s     = 1'b1;
                        edge_num_s = EDGE_ONE;
                        if (wrap_s) begin
                            edge_now_s = 1'b1;
                            sclk_d     = ~sclk_q;
                            edge_d     = EDGE_ONE;
                        end else begin
                            edge_d = EDGE_ZERO;
                        end
                    end else begin
                        state_d = ST_TRAIL;
                        cnt_d   = 8'd0;
                        edge_d  = EDGE_ZERO;
                    end
                end else if (wrap_s) begin
                    edge_now_s = 1'b1;
                    sclk_d     = ~sclk_q;
                    edge_d     = edge_num_s;
                end else begin
                    edge_d = edge_q;
                end
            end
            ST_TRAIL: begin
                if (wrap_s) begin
                    state_d = ST_IDLE;
                    ss_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ss_n_d  = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = 8'd0;
                edge_d  = EDGE_ZERO;
            end
        endcase

        // With cpha=1 the first drive edge re-presents bit 0, so keep it in the register.
        if (load_s) begin
            mosi_d = first_bit(tx_data);
            if (cpha_d) begin
                tx_sr_d = tx_data;
            end else begin
                tx_sr_d = shift_out(tx_data);
            end
        end else begin
            tx_sr_d = tx_sr_q;
        end

        if (edge_now_s) begin
            if (edge_num_s[0] ^ cpha_q) begin
                rx_sr_d = shift_in(rx_sr_q, miso);
            end else if (edge_num_s != LAST_EDGE) begin
                mosi_d  = first_bit(tx_sr_d);
                tx_sr_d = shift_out(tx_sr_d);
            end else if (cont_q && enable) begin
                // Present the next word's first bit a half-period ahead of its leading edge.
                mosi_d = first_bit(tx_data);
            end else begin
                mosi_d = mosi_q;
            end
        end else begin
            rx_sr_d = rx_sr_q;
        end
    end

    // State and output registers; reset aborts any transfer immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            edge_q     <= EDGE_ZERO;
            div_q      <= 8'd0;
            cpha_q     <= 1'b0;
            cont_q     <= 1'b0;
            tx_sr_q    <= {D_WIDTH{1'b0}};
            rx_sr_q    <= {D_WIDTH{1'b0}};
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            ss_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            rx_data_q  <= {D_WIDTH{1'b0}};
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            edge_q     <= edge_d;
            div_q      <= div_d;
            cpha_q     <= cpha_d;
            cont_q     <= cont_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            ss_n_q     <= ss_n_d;
            busy_q     <= busy_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign ss_n     = ss_n_q;
    assign busy     = busy_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Testbench for spi_shift_engine: directed and randomized transfers checked
// against a cycle/edge-level reference model of the SPI timing rules.
// Honors SPI_SHIFT_LSB_FIRST_EN for the expected bit order.
module tb_spi_shift_engine;
    localparam int W = 8;
    localparam int E = 2 * W;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         enable = 1'b0;
    logic         cpol = 1'b0;
    logic         cpha = 1'b0;
    logic         cont = 1'b0;
    logic [7:0]   clk_div = 8'd0;
    logic [W-1:0] tx_data = 8'h00;
    logic         miso;
    logic         sclk, mosi, ss_n, busy, rx_valid;
    logic [W-1:0] rx_data;

    int           n_checks = 0;
    int           n_errors = 0;

    // Slave model state: loopback flag, words to return, SCLK edges seen so far.
    logic         loop_mode = 1'b0;
    logic [W-1:0] slave_w [2];
    int           seen = 0;
    logic         slave_bit;

    spi_shift_engine #(.D_WIDTH(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .cpol     (cpol),
        .cpha     (cpha),
        .cont     (cont),
        .clk_div  (clk_div),
        .tx_data  (tx_data),
        .miso     (miso),
        .sclk     (sclk),
        .mosi     (mosi),
        .ss_n     (ss_n),
        .busy     (busy),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
    );

    always #5 clk = ~clk;

    // j-th bit of a word in wire order.
    function automatic logic seq_bit(input logic [W-1:0] w, input int j);
`ifdef SPI_SHIFT_LSB_FIRST_EN
        return w[j];
`else
        return w[W-1-j];
`endif
    endfunction

    // Slave presents bit (edges_seen mod 2W)/2 of the current word; this fits both cpha modes.
    assign slave_bit = seq_bit(slave_w[(seen >= E) ? 1 : 0], (seen % E) / 2);
    assign miso = loop_mode ? mosi : slave_bit;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transfer of nw words (nw=2 uses continuous mode), then compare timing and data.
    task automatic run_xfer(input logic pol, input logic pha, input logic [7:0] div,
                            input logic [7:0] div_mid, input logic [W-1:0] w0,
                            input logic [W-1:0] w1, input int nw, input logic [W-1:0] s0,
                            input logic [W-1:0] s1, input logic loop);
        int           cyc, fall, ss_bad, hp;
        logic         prev_sclk, end_sclk, end_ss;
        int           e_cyc[$];
        logic         e_mosi[$];
        int           v_cyc[$];
        logic [W-1:0] v_dat[$];
        @(negedge clk);
        enable = 1'b0; cpol = pol; cpha = pha; clk_div = div; cont = (nw == 2);
        tx_data = w0; loop_mode = loop; slave_w[0] = s0; slave_w[1] = s1; seen = 0;
        @(negedge clk);
        check("idle_sclk", sclk, pol);
        check("idle_ss_n", ss_n, 1);
        check("idle_busy", busy, 0);
        enable = 1'b1;
        prev_sclk = sclk; cyc = 0; fall = -1; ss_bad = 0; end_sclk = 1'b0; end_ss = 1'b0;
        while (fall < 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (sclk !== prev_sclk) begin
                e_cyc.push_back(cyc);
                e_mosi.push_back(mosi);
                seen++;
            end
            prev_sclk = sclk;
            if (rx_valid) begin
                v_cyc.push_back(cyc);
                v_dat.push_back(rx_data);
                if (nw == 2 && v_cyc.size() == 1) enable = 1'b0;
            end
            if (!busy) begin
                fall = cyc; end_sclk = sclk; end_ss = ss_n;
            end else if (ss_n !== 1'b0) begin
                ss_bad++;
            end
            if (cyc == 1) begin
                // Everything except enable/tx_data/cont must be ignored from here on.
                enable = (nw == 2); cont = 1'b0; tx_data = w1;
                clk_div = div_mid; cpol = ~pol; cpha = ~pha;
            end
        end
        enable = 1'b0; cpol = pol;
        hp = int'(div) + 1;
        check("edge_count", e_cyc.size(), E * nw);
        foreach (e_cyc[k]) begin
            check("edge_cycle", e_cyc[k], 1 + (k + 1) * hp);
            if (((k % E) % 2 == 0) != pha)
                check("mosi_bit", e_mosi[k], seq_bit((k < E) ? w0 : w1, (k % E) / 2));
        end
        check("rx_valid_count", v_cyc.size(), nw);
        foreach (v_cyc[m]) begin
            check("rx_valid_cycle", v_cyc[m], 2 + E * (m + 1) * hp);
            check("rx_data", v_dat[m], loop ? ((m == 0) ? w0 : w1) : ((m == 0) ? s0 : s1));
        end
        check("busy_fall_cycle", fall, 2 + (E * nw + 1) * hp);
        check("ss_n_low_during", ss_bad, 0);
        check("ss_n_end", end_ss, 1);
        check("sclk_end", end_sclk, pol);
    endtask

    int   cyc, ne, nv;
    logic prev;

    // Stimulus sequence: reset, directed cases, abort, randomized transfers.
    initial begin
        #12;
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_ss_n", ss_n, 1);
        check("rst_busy", busy, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Mode 0, fastest clock, loopback of A5.
        run_xfer(1'b0, 1'b0, 8'd0, 8'd0, 8'hA5, 8'h00, 1, 8'h00, 8'h00, 1'b1);
        // Mode 3, half-period 4, slave returns 3C.
        run_xfer(1'b1, 1'b1, 8'd3, 8'd3, 8'h96, 8'h00, 1, 8'h3C, 8'h00, 1'b0);
        // Continuous burst 11 then 22.
        run_xfer(1'b0, 1'b0, 8'd1, 8'd1, 8'h11, 8'h22, 2, 8'hC3, 8'h5E, 1'b0);
        run_xfer(1'b0, 1'b0, 8'd0, 8'd0, 8'h11, 8'h22, 2, 8'h00, 8'h00, 1'b1);
        // clk_div changed 2 -> 7 mid-transfer.
        run_xfer(1'b0, 1'b1, 8'd2, 8'd7, 8'h6B, 8'h00, 1, 8'h81, 8'h00, 1'b0);
        // Single set bit in the low position.
        run_xfer(1'b0, 1'b0, 8'd0, 8'd0, 8'h01, 8'h00, 1, 8'h01, 8'h00, 1'b0);

        // Abort at the fifth SCLK edge.
        @(negedge clk);
        loop_mode = 1'b1; cpol = 1'b1; cpha = 1'b0; clk_div = 8'd1; cont = 1'b0; tx_data = 8'h5A;
        @(negedge clk);
        enable = 1'b1; prev = sclk; ne = 0; cyc = 0;
        while (ne < 5 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            enable = 1'b0;
            if (sclk !== prev) ne++;
            prev = sclk;
        end
        check("abort_edge_reached", ne, 5);
        reset_n = 1'b0;
        #1;
        check("abort_ss_n", ss_n, 1);
        check("abort_busy", busy, 0);
        check("abort_sclk", sclk, 0);
        check("abort_mosi", mosi, 0);
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 2) reset_n = 1'b1;
            if (rx_valid) nv++;
        end
        check("abort_no_rx_valid", nv, 0);
        check("abort_rx_data", rx_data, 0);
        run_xfer(1'b0, 1'b0, 8'd1, 8'd1, 8'hF0, 8'h00, 1, 8'h0F, 8'h00, 1'b1);

        // Randomized modes, dividers, words, burst lengths and slave behaviour.
        for (int t = 0; t < 12; t++) begin
            run_xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 4)),
                     8'($urandom_range(0, 255)), 8'($urandom), 8'($urandom),
                     int'($urandom_range(1, 2)), 8'($urandom), 8'($urandom),
                     1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
